// File: rtl/uart_pkg.sv
// Shared UART types and elaboration helpers for the receive (and future transmit) path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_rx_state_e;

  // Integer clocks per bit; callers must keep the result >= 8.
  function automatic int unsigned clks_per_bit(input int unsigned freq, input int unsigned baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; pop on empty is ignored, push on full
// is accepted only when a pop frees the head slot in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             push_ok_c;
  logic             pop_ok_c;

  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count    = wr_q - rd_q;
  assign pop_data = mem_q[rd_q[AW-1:0]];

  always_comb begin
    mem_d     = mem_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    pop_ok_c  = pop & ~empty;
    push_ok_c = push & (~full | pop_ok_c);
    if (push_ok_c) begin
      mem_d[wr_q[AW-1:0]] = push_data;
      wr_d                = wr_q + (AW+1)'(1);
    end
    if (pop_ok_c) begin
      rd_d = rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

endmodule

// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM, error flags, and a byte FIFO
// presented to the consumer with a valid/ready handshake.
module uart_rx_monitor
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16,
  localparam int unsigned COUNT_W   = $clog2(FIFO_DEPTH + 1)
) (
  input  logic               io_clock,
  input  logic               io_reset,
  input  logic               io_rxd,
  output logic [7:0]         io_data,
  output logic               io_valid,
  input  logic               io_ready,
  output logic [COUNT_W-1:0] io_count,
  output logic               io_frameError,
  output logic               io_overflow
);

  localparam int unsigned CPB       = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned BIT_CNT_W = $clog2(CPB);

  logic                 rxd_meta_q, rxd_meta_d;
  logic                 rxd_s_q, rxd_s_d;
  uart_rx_state_e       state_q, state_d;
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [7:0]           shift_q, shift_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overflow_q, overflow_d;
  logic                 push_c;
  logic                 pop_c;
  logic                 fifo_full;
  logic                 fifo_empty;

  assign io_valid      = ~fifo_empty;
  assign pop_c         = io_valid & io_ready;
  assign io_frameError = frame_err_q;
  assign io_overflow   = overflow_q;

  // Next-state logic; the counter is loaded so that every sample lands mid-bit.
  always_comb begin
    rxd_meta_d  = io_rxd;
    rxd_s_d     = rxd_meta_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    overflow_d  = overflow_q;
    push_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rxd_s_q) begin
          cnt_d   = BIT_CNT_W'(CPB / 2 - 1);
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (rxd_s_q) begin
            state_d = IDLE;
          end else begin
            cnt_d   = BIT_CNT_W'(CPB - 1);
            idx_d   = 3'd0;
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q - BIT_CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shift_d[idx_q] = rxd_s_q;
          idx_d          = idx_q + 3'd1;
          cnt_d          = BIT_CNT_W'(CPB - 1);
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q - BIT_CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (rxd_s_q) begin
            push_c  = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q - BIT_CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        // A held-low line (break) must not look like a new start bit.
        if (rxd_s_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push_c && fifo_full && !pop_c) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      rxd_meta_q  <= 1'b1;
      rxd_s_q     <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      rxd_meta_q  <= rxd_meta_d;
      rxd_s_q     <= rxd_s_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (io_clock),
    .rst       (io_reset),
    .push      (push_c),
    .push_data (shift_q),
    .pop       (pop_c),
    .pop_data  (io_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (io_count)
  );

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Self-checking bench for uart_rx_monitor: table of frames plus directed corner sequences,
// received bytes checked against an expected-byte queue.
module tb_uart_rx_monitor;

  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int unsigned CPB      = CLK_FREQ / BAUD;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned CW       = $clog2(DEPTH + 1);
  localparam int unsigned NVEC     = 8;

  typedef struct {
    logic [7:0]  data;
    logic        stop_ok;
    int unsigned exp_fe;
  } vec_t;

  logic          io_clock = 1'b0;
  logic          io_reset;
  logic          io_rxd;
  logic [7:0]    io_data;
  logic          io_valid;
  logic          io_ready;
  logic [CW-1:0] io_count;
  logic          io_frameError;
  logic          io_overflow;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         fe_cycles = 0;
  int         valid_cycles = 0;
  int         rx_bytes = 0;
  int         fe0;
  int         rx0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  vec_t       vecs[NVEC];

  uart_rx_monitor #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .io_clock      (io_clock),
    .io_reset      (io_reset),
    .io_rxd        (io_rxd),
    .io_data       (io_data),
    .io_valid      (io_valid),
    .io_ready      (io_ready),
    .io_count      (io_count),
    .io_frameError (io_frameError),
    .io_overflow   (io_overflow)
  );

  always #5 io_clock = ~io_clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Consumer-side scoreboard: every handshake pops one expected byte.
  always @(negedge io_clock) begin
    #1;
    if (io_frameError) fe_cycles++;
    if (io_valid) valid_cycles++;
    if (io_valid && io_ready && !io_reset) begin
      rx_bytes++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_byte: got 0x%02h with no byte expected at %0t", io_data, $time);
      end else begin
        exp_b = exp_q.pop_front();
        check("rx_byte", 32'(io_data), 32'(exp_b));
      end
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge io_clock);
  endtask

  // Starts on a negedge and ends on a negedge with the line back at idle.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    io_rxd = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      io_rxd = b[i];
      idle(CPB);
    end
    io_rxd = stop;
    idle(CPB);
    io_rxd = 1'b1;
  endtask

  task automatic wait_drain(input int unsigned budget);
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge io_clock);
      n++;
    end
    check("drain_remaining", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data"},  32'(io_data), 32'd0);
    check({tag, "_valid"}, 32'(io_valid), 32'd0);
    check({tag, "_count"}, 32'(io_count), 32'd0);
    check({tag, "_fe"},    32'(io_frameError), 32'd0);
    check({tag, "_ovf"},   32'(io_overflow), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h55, 1'b1, 0};
    vecs[1] = '{8'hA3, 1'b1, 0};
    vecs[2] = '{8'h3C, 1'b0, 1};
    vecs[3] = '{8'h7E, 1'b1, 0};
    vecs[4] = '{8'h00, 1'b1, 0};
    vecs[5] = '{8'hFF, 1'b1, 0};
    vecs[6] = '{8'h96, 1'b0, 1};
    vecs[7] = '{8'h01, 1'b1, 0};

    io_reset = 1'b1;
    io_rxd   = 1'b1;
    io_ready = 1'b0;
    idle(4);
    io_reset = 1'b0;
    #1;
    check_reset_values("reset");

    // Table: each frame followed by idle time, consumer always ready.
    idle(1);
    io_ready = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      fe0 = fe_cycles;
      rx0 = rx_bytes;
      if (vecs[i].stop_ok) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop_ok);
      idle(2 * CPB);
      #1;
      check("fe_pulse_cycles", 32'(fe_cycles - fe0), 32'(vecs[i].exp_fe));
      check("rx_delta", 32'(rx_bytes - rx0), 32'(vecs[i].stop_ok));
      check("count_after", 32'(io_count), 32'd0);
      check("ovf_after", 32'(io_overflow), 32'd0);
      idle(1);
    end
    check("valid_one_cycle_each", 32'(valid_cycles), 32'(rx_bytes));
    check("table_queue_empty", 32'(exp_q.size()), 32'd0);

    // Start glitch shorter than half a bit.
    rx0 = rx_bytes;
    io_rxd = 1'b0;
    idle(5);
    io_rxd = 1'b1;
    idle(3 * CPB);
    #1;
    check("glitch_count", 32'(io_count), 32'd0);
    check("glitch_valid", 32'(io_valid), 32'd0);
    check("glitch_rx", 32'(rx_bytes - rx0), 32'd0);

    // Overflow: 17 back-to-back frames into a stalled consumer.
    idle(1);
    io_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1);
    end
    idle(2 * CPB);
    #1;
    check("ovf_count", 32'(io_count), 32'd16);
    check("ovf_flag", 32'(io_overflow), 32'd1);
    check("ovf_valid", 32'(io_valid), 32'd1);
    check("ovf_head", 32'(io_data), 32'h00);
    idle(1);
    io_ready = 1'b1;
    wait_drain(4 * DEPTH);
    idle(2);
    #1;
    check("ovf_drained_count", 32'(io_count), 32'd0);
    check("ovf_sticky", 32'(io_overflow), 32'd1);

    idle(1);
    io_reset = 1'b1;
    idle(2);
    io_reset = 1'b0;
    exp_q.delete();
    #1;
    check_reset_values("ovf_reset");

    // Full FIFO with a pop in exactly the stop-sample (push) cycle.
    idle(1);
    io_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(8'h20 + i));
      send_frame(8'(8'h20 + i), 1'b1);
    end
    exp_q.push_back(8'h30);
    fork
      send_frame(8'h30, 1'b1);
      begin
        idle(2 + CPB / 2 + 9 * CPB);
        io_ready = 1'b1;
        idle(1);
        io_ready = 1'b0;
      end
    join
    idle(2 * CPB);
    #1;
    check("fullpop_count", 32'(io_count), 32'd16);
    check("fullpop_ovf", 32'(io_overflow), 32'd0);
    check("fullpop_head", 32'(io_data), 32'h21);
    idle(1);
    io_ready = 1'b1;
    wait_drain(4 * DEPTH);
    idle(2);
    #1;
    check("fullpop_drained", 32'(io_count), 32'd0);

    // Reset during data bit 4 of 0xF0 with a byte already buffered.
    idle(1);
    io_ready = 1'b0;
    exp_q.push_back(8'h99);
    send_frame(8'h99, 1'b1);
    idle(CPB);
    #1;
    check("prereset_count", 32'(io_count), 32'd1);
    idle(1);
    fork
      send_frame(8'hF0, 1'b1);
      begin
        idle(5 * CPB + CPB / 2);
        io_reset = 1'b1;
        idle(1);
        io_reset = 1'b0;
        exp_q.delete();
        #1;
        check_reset_values("midframe_reset");
      end
    join
    idle(1);
    io_ready = 1'b1;
    fe0 = fe_cycles;
    rx0 = rx_bytes;
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    idle(2 * CPB);
    wait_drain(4 * CPB);
    #1;
    check("post_reset_rx", 32'(rx_bytes - rx0), 32'd1);
    check("post_reset_fe", 32'(fe_cycles - fe0), 32'd0);
    check("post_reset_count", 32'(io_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_monitor.md
# uart_rx_monitor

Synthesizable UART receiver that consumes the SoC's standard UART transmit line (`io_uartStd_txd`) and turns it into a byte stream with valid/ready handshake, backed by a small FIFO. It sits directly downstream of the top-level SoC in simulation benches and FPGA loopback harnesses. Framing and overflow errors are flagged so the bench can check console output byte-exact.

## Interface
- `CLK_FREQ`, 100_000_000: `io_clock` frequency in Hz.
- `BAUD`, 115200: line rate. `CLKS_PER_BIT = CLK_FREQ / BAUD`, integer division, so 868 at the defaults. It must be ≥ 8.
- `FIFO_DEPTH`, 16: number of received bytes buffered. Power of two, ≥ 2.

- `io_clock`: in, 1. Single clock. Everything is rising-edge.
- `io_reset`: in, 1. Synchronous, active-high reset.
- `io_rxd`: in, 1. Serial input, idle high, asynchronous to `io_clock`.
- `io_data`: out, 8. Byte at the FIFO head. LSB is the first received bit.
- `io_valid`: out, 1. FIFO is non-empty.
- `io_ready`: in, 1. Consumer accepts. A pop happens when `io_valid & io_ready`.
- `io_count`: out, $clog2(FIFO_DEPTH+1). Current FIFO occupancy.
- `io_frameError`: out, 1. One-cycle pulse when a stop bit is sampled low.
- `io_overflow`: out, 1. Sticky. Set when a good byte is dropped because the FIFO is full. Cleared only by reset.

## Operation
- `io_rxd` passes through a 2-flop synchronizer. Its reset value is 1 (idle). All logic below uses the synchronized value `rxd_s`.
- The FSM has the states IDLE, START, DATA, STOP and WAIT_HIGH.
  - IDLE: when `rxd_s` = 0, load the bit counter with `CLKS_PER_BIT/2 - 1` and go to START.
  - START: when the counter expires, sample `rxd_s`. If 1, it was a glitch: return to IDLE and push nothing. If 0, go to DATA with bit index 0.
  - DATA: every `CLKS_PER_BIT` cycles, shift `rxd_s` into bit [index], LSB first. After bit 7, go to STOP.
  - STOP: one `CLKS_PER_BIT` later, sample `rxd_s`.
    - If 1: push the byte and go to IDLE.
    - If 0: pulse `io_frameError`, discard the byte and go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxd_s` = 1, then go to IDLE. This prevents a break condition from retriggering.
- FIFO behaviour:
  - Push when not full, or when full with a pop in the same cycle. Otherwise drop the byte and set `io_overflow`.
  - A pop when empty is ignored.
  - A simultaneous push and pop leaves `io_count` unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`. An extra wrap bit distinguishes full from empty.
- `io_data` is stable while `io_valid` is high and not popped.
- Reset values:
  - FSM in IDLE, counters 0, synchronizer at 1.
  - FIFO empty, so `io_valid` = 0 and `io_count` = 0.
  - `io_data` = 0, `io_frameError` = 0, `io_overflow` = 0.
- Reset mid-frame: the partial byte is discarded. The next full frame after reset decodes correctly.

## Timing
- Let t0 be the first cycle with `rxd_s` = 0 in IDLE, which is 2 cycles after the `io_rxd` edge.
- Sample points:
  - Start-bit check at t0 + `CLKS_PER_BIT/2`.
  - Data bit i at t0 + `CLKS_PER_BIT/2` + (i+1)·`CLKS_PER_BIT`.
  - Stop bit at t0 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`.
- Push is registered on the stop-sample cycle. `io_valid` and `io_count` update on the next cycle, i.e. 1-cycle latency from the stop sample.
- `io_frameError` is high exactly during the cycle after the stop sample.
- A pop is registered: `io_data` and `io_valid` show the new head on the cycle after the handshake.
- Back-to-back frames with zero idle time are decoded without loss. The FSM is in IDLE by mid-stop-bit.
- Baud tolerance is ±2 % cumulative over 10 bits.

## Structure
- Package `uart_pkg`:
  - `typedef enum logic [2:0] uart_rx_state_e {IDLE, START, DATA, STOP, WAIT_HIGH}`.
  - Localparam helper function `clks_per_bit(freq, baud)`.
- Sub-module `sync_fifo`, parameterized by WIDTH and DEPTH, with push/pop/full/empty/count. It is reusable by a future `uart_tx_driver`.
- The top level holds the synchronizer, FSM, bit counter, shift register and error flags.

## Test plan
- Send 0x55, then 0xA3, at 115200 with `io_ready` = 1. Expect `io_data` to equal 0x55, then 0xA3, each `io_valid` for 1 cycle. `io_frameError` and `io_overflow` stay 0.
- Drive a 100-cycle low glitch on `io_rxd`, which is shorter than `CLKS_PER_BIT/2`. Expect no push and `io_count` = 0.
- Send frame 0x3C with the stop bit forced low for 1 bit, then idle high. Expect a one-cycle `io_frameError` pulse, `io_count` = 0, and a following 0x7E received correctly.
- Hold `io_ready` = 0 and send 17 bytes 0x00..0x10. Expect `io_count` = 16 and `io_overflow` = 1. Then raise `io_ready`: expect 0x00..0x0F in order, with 0x10 lost.
- With the FIFO full, pop in the same cycle as a push. Expect `io_count` to stay at 16 and `io_overflow` to stay 0.
- Assert `io_reset` for 1 cycle during data bit 4 of 0xF0. Expect all outputs at their reset values; the next frame, 0x81, is received as 0x81.
